// File: rtl/rx_spart_if.sv
// Processor-side register interface of the SPART receive half.
// The processor (master) drives chip select, direction and address.
// The receiver (slave) returns the buffer contents and its status flags.
interface rx_spart_if #(
    parameter int DATA_BITS = 8
);
    logic                 iocs;
    logic                 iorw;
    logic [1:0]           ioaddr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 ferr;

    modport master (
        output iocs, iorw, ioaddr,
        input  rx_data, rda, ferr
    );

    modport slave (
        input  iocs, iorw, ioaddr,
        output rx_data, rda, ferr
    );
endinterface

// File: rtl/rx_spart.sv
// SPART receive half: deserializes an 8N1 stream on rxd into a one-byte
// buffer. A set rda flags a new byte and a processor read of data
// register 00 clears it. Bit timing comes from the shared baud-rate
// oversample tick brg_en. A framing error raises ferr, which stays set
// until the next good frame.
module rx_spart #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    input  logic      brg_en,
    rx_spart_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e               state_q,   state_d;
    logic [TW-1:0]        tick_q,    tick_d;
    logic [BW-1:0]        bitcnt_q,  bitcnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rda_q,     rda_d;
    logic                 ferr_q,    ferr_d;

    logic sync1_q;
    logic sync2_q;
    logic rxs;
    logic rd;

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, whatever the statement order.
        if (!rst) begin
            // NOTE: the synchronizer resets to the idle-high line level, so
            // leaving reset never looks like a start-bit edge.
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;
    assign rd  = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);

    // Next-state logic: frame FSM, bit sampling and buffer/status updates.
    always_comb begin
        // NOTE: every next-state value first takes its hold value, so no path
        // through the case statement can leave a latch behind.
        state_d   = state_q;
        tick_d    = tick_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rda_d     = rda_q;
        ferr_d    = ferr_q;

        // A read clears rda first so a good stop on the same edge overrides it.
        if (rd) begin
            rda_d = 1'b0;
        end

        if (brg_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_MID) begin
                        if (rxs) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = DATA;
                            tick_d   = '0;
                            bitcnt_d = '0;
                        end
                    end
                end
                DATA: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_LAST) begin
                        shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
                        tick_d   = '0;
                        bitcnt_d = bitcnt_q + BW'(1);
                        if (bitcnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    tick_d = tick_q + TW'(1);
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        state_d = IDLE;
                        if (rxs) begin
                            rx_data_d = shift_q;
                            rda_d     = 1'b1;
                            ferr_d    = 1'b0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter, shift and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            rda_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rda_q     <= rda_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rda     = rda_q;
    assign bus.ferr    = ferr_q;
endmodule

// File: tb/tb_rx_spart.sv
// Testbench for rx_spart: a table of frames with explicit expected results,
// hand-written corner sequences, and random frames checked against a
// frame-level reference model (byte + stop bit -> buffer and flag state).
module tb_rx_spart;
    localparam int DIV        = 4;              // clk per brg_en tick
    localparam int OS         = 16;
    localparam int BIT_CLKS   = OS * DIV;       // 64 clk per bit
    localparam int FRAME_CLKS = 10 * BIT_CLKS;  // start + 8 data + stop

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic brg_en;

    rx_spart_if #(.DATA_BITS(8)) bus ();

    rx_spart #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .brg_en (brg_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_data;
    logic       m_rda;
    logic       m_ferr;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         op;        // -1 none, else bus_op kind
        logic [7:0] e_data;
        logic       e_rda;
        logic       e_ferr;
        logic       e_rda_op;  // rda after the bus op
    } vec_t;

    vec_t vecs[10];

    // Oversample tick: one clk high every DIV clk, runs through reset too.
    initial begin
        int cnt;
        cnt    = 0;
        brg_en = 1'b0;
        forever begin
            @(negedge clk);
            brg_en = (cnt == DIV - 1);
            cnt    = (cnt + 1) % DIV;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, 32'(bus.rx_data), 32'(m_data));
        check({tag, ".rda"},  32'(bus.rda),     32'(m_rda));
        check({tag, ".ferr"}, 32'(bus.ferr),    32'(m_ferr));
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Frame-level reference: good stop loads the byte, bad stop only flags.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            m_data = b;
            m_rda  = 1'b1;
            m_ferr = 1'b0;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    // One-clk bus cycle: 0 data read, 1 write to data, 2 read other addr,
    // 3 read with chip select low. Only kind 0 is a real read.
    task automatic bus_op(input int kind);
        bus.iocs   = (kind != 3);
        bus.iorw   = (kind != 1);
        bus.ioaddr = (kind == 2) ? 2'(1 + $urandom_range(0, 2)) : 2'b00;
        @(negedge clk);
        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;
        if (kind == 0) m_rda = 1'b0;
    endtask

    // Drive one 8N1 frame. rd_at: iteration in which a data read is strobed.
    // rst_at: iteration in which reset is pulsed; the frame is then abandoned.
    // rise: iteration after whose edge rda first went 0 -> 1 (-1 if never).
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int rd_at, input int rst_at, output int rise);
        logic [9:0] bits;
        logic       prev;
        bits = {stop, b, 1'b0};
        rise = -1;
        prev = bus.rda;
        for (int c = 0; c < FRAME_CLKS; c++) begin
            rxd = bits[c / BIT_CLKS];
            if (c == rd_at) begin
                bus.iocs   = 1'b1;
                bus.iorw   = 1'b1;
                bus.ioaddr = 2'b00;
            end
            if (c == rst_at) rst = 1'b0;
            @(negedge clk);
            bus.iocs = 1'b0;
            bus.iorw = 1'b0;
            rst      = 1'b1;
            if (rise < 0 && bus.rda && !prev) rise = c;
            prev = bus.rda;
            if (c == rst_at) begin
                check("midrst.data", 32'(bus.rx_data), 32'h0);
                check("midrst.rda",  32'(bus.rda),     32'h0);
                check("midrst.ferr", 32'(bus.ferr),    32'h0);
                rxd = 1'b1;
                return;
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        int rise;
        int r;
        logic [7:0] b;
        logic       stop;
        int         kind;

        vecs[0] = '{8'hA5, 1'b1,  0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b0,  1, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h0F, 1'b1,  2, 8'h0F, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'h33, 1'b1,  3, 8'h33, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h44, 1'b1,  0, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 1'b0,  0, 8'h44, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, -1, 8'hFF, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{8'h00, 1'b1,  0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h80, 1'b0, -1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h01, 1'b1,  0, 8'h01, 1'b1, 1'b0, 1'b0};

        bus.iocs   = 1'b0;
        bus.iorw   = 1'b0;
        bus.ioaddr = 2'b00;

        // Reset held 3 clk with the line low and brg_en running
        rst = 1'b0;
        rxd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset.data", 32'(bus.rx_data), 32'h0);
            check("reset.rda",  32'(bus.rda),     32'h0);
            check("reset.ferr", 32'(bus.ferr),    32'h0);
        end
        rst = 1'b1;
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        idle(2 * BIT_CLKS);
        check_model("post_reset");

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, -1, -1, rise);
            idle(BIT_CLKS);
            if (i == 0) check_range("vec0.rise", rise, 608, 616);
            check($sformatf("vec%0d.data", i), 32'(bus.rx_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d.rda", i),  32'(bus.rda),     32'(vecs[i].e_rda));
            check($sformatf("vec%0d.ferr", i), 32'(bus.ferr),    32'(vecs[i].e_ferr));
            if (vecs[i].op >= 0) begin
                bus_op(vecs[i].op);
                check($sformatf("vec%0d.op_rda", i),  32'(bus.rda),     32'(vecs[i].e_rda_op));
                check($sformatf("vec%0d.op_data", i), 32'(bus.rx_data), 32'(vecs[i].e_data));
                check($sformatf("vec%0d.op_ferr", i), 32'(bus.ferr),    32'(vecs[i].e_ferr));
            end
        end
        m_data = 8'h01;
        m_rda  = 1'b0;
        m_ferr = 1'b0;

        // False start: line low for 3 oversample ticks only
        rxd = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        idle(2 * BIT_CLKS);
        check_model("false_start");
        send_frame(8'h3C, 1'b1, -1, -1, rise);
        model_frame(8'h3C, 1'b1);
        idle(BIT_CLKS);
        check_model("after_false");
        bus_op(0);

        // Back-to-back frames; read strobe on the 0x22 stop-sample cycle
        send_frame(8'h11, 1'b1, -1, -1, r);
        model_frame(8'h11, 1'b1);
        check_model("b2b_11");
        check_range("b2b_11.rise", r, 608, 616);
        send_frame(8'h22, 1'b1, r, -1, rise);
        model_frame(8'h22, 1'b1);
        check_model("collide_22");

        // Overrun: 0x33 unread, then 0x44
        send_frame(8'h33, 1'b1, -1, -1, rise);
        model_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1, -1, -1, rise);
        model_frame(8'h44, 1'b1);
        idle(BIT_CLKS);
        check_model("overrun_44");

        // Framing error with rda set, then reset during data bit 4
        send_frame(8'h5A, 1'b0, -1, -1, rise);
        model_frame(8'h5A, 1'b0);
        idle(BIT_CLKS);
        check_model("ferr_keep_rda");
        send_frame(8'h96, 1'b1, -1, 5 * BIT_CLKS + BIT_CLKS / 2, rise);
        m_data = 8'h00;
        m_rda  = 1'b0;
        m_ferr = 1'b0;
        idle(BIT_CLKS);
        check_model("after_midrst");
        send_frame(8'hC3, 1'b1, -1, -1, rise);
        model_frame(8'hC3, 1'b1);
        idle(BIT_CLKS);
        check_model("recover_C3");

        // Random frames and bus activity against the frame-level model
        for (int i = 0; i < 20; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, -1, -1, rise);
            model_frame(b, stop);
            idle(BIT_CLKS * $urandom_range(1, 2));
            check_model($sformatf("rand%0d", i));
            kind = $urandom_range(0, 3);
            bus_op(kind);
            check($sformatf("rand%0d.op_rda", i), 32'(bus.rda), 32'(m_rda));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_spart.md
Name: rx_spart

Overview:
- Receive half of the SPART. Deserializes an asynchronous 8N1 serial stream on rxd into a one-byte receive buffer.
- Raises rda (receive data available) for the processor bus interface.
- Uses the same baud-rate-generator enable (brg_en, one pulse per 1/OVERSAMPLE bit time) as the transmit half.
- Sits beside the transmit half inside the SPART top level. Bus tristating of rx_data onto the databus is done outside this block.

Parameters:
- OVERSAMPLE, 16, brg_en ticks per bit period (power of 2, >=8)
- DATA_BITS, 8, data bits per frame, LSB first

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- rxd  input  1  asynchronous serial line, idle high
- brg_en  input  1  oversample tick, 1-clk pulse
- iocs  input  1  SPART chip select
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  register address; 2'b00 = data register
- rx_data  output  DATA_BITS  receive buffer contents
- rda  output  1  receive data available
- ferr  output  1  framing error on last frame

Behaviour:
- Reset: when rst==0 at a clk edge, all of the following are loaded on that edge:
  - state=IDLE; tick and bit counters=0; shift reg=0
  - rx_data=0, rda=0, ferr=0
  - synchronizer flops=1
- Synchronizer:
  - rxd passes through 2 flops; only the second-stage value (rxs) is used.
  - Input-to-rxs latency is 2 clk.
- Counters: all counters advance only on cycles with brg_en==1. With brg_en==0, state and counters hold.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on brg_en && rxs==0, go to START and set tick=0.
- START:
  - Increment tick each brg_en.
  - On the brg_en where tick==OVERSAMPLE/2-1 (mid start bit), sample rxs.
  - Sample 1 -> false start, return to IDLE.
  - Sample 0 -> set tick=0, bitcnt=0, go to DATA.
- DATA:
  - On the brg_en where tick==OVERSAMPLE-1, sample rxs, shift it in at the MSB (LSB-first frame), set tick=0, increment bitcnt.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: on the brg_en where tick==OVERSAMPLE-1, sample rxs.
  - Sample 1 -> rx_data <= shift reg, rda <= 1, ferr <= 0.
  - Sample 0 -> ferr <= 1; rx_data and rda unchanged; byte discarded.
  - In both cases go to IDLE on the same edge. A low line then re-triggers start detection in IDLE.
- Output latency: rx_data, rda and ferr update on the clk edge of the stop-sample tick and are visible the following cycle.
- Read strobe: rd = iocs && iorw && ioaddr==2'b00. rd is combinational and level-sensitive per cycle.
- rda clears on the clk edge where rd==1.
- rx_data is a stable register output; a read does not alter it.
- Simultaneous good-stop and rd in the same cycle: the set wins. rda stays 1 and rx_data takes the new byte.
- Overrun (good stop while rda==1): rx_data is overwritten, rda stays 1, no error flag.
- ferr is sticky until the next good stop or reset; rd does not clear it.
- Writes (iorw==0) and other ioaddr values: no effect on this block.
- Reset mid-frame: the frame is abandoned, the FSM goes to IDLE and all outputs return to reset values.
- After reset, the block does not resume mid-frame. Stray data bits may produce a false start or a framing error, which is acceptable.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 clk with rxd=0 and brg_en toggling.
  - Response: rx_data=8'h00, rda=0, ferr=0 throughout; state is IDLE on release.
- Single byte:
  - Stimulus: brg_en every 4 clk (bit = 64 clk); send 0xA5 as start, 1,0,1,0,0,1,0,1, stop=1.
  - Response: rda rises about 9.5 bit times after the start edge; rx_data=8'hA5, ferr=0.
  - Then: iocs=1, iorw=1, ioaddr=00 for 1 clk -> rda=0 next cycle, rx_data still 8'hA5.
- False start:
  - Stimulus: pulse rxd low for 3 brg_en ticks, then high.
  - Response: no state change beyond START, rda=0, ferr=0.
  - Then: a following 0x3C frame is received correctly.
- Framing error:
  - Stimulus: send 0x5A with stop bit = 0.
  - Response: ferr=1, rda unchanged (0), rx_data unchanged.
  - Then: a good 0x0F frame -> ferr=0, rda=1, rx_data=8'h0F.
- Back-to-back, read collision and overrun:
  - Stimulus: send 0x11 then immediately 0x22; assert the rd strobe on exactly the stop-sample cycle of 0x22.
  - Response: rda=1, rx_data=8'h22.
  - Stimulus: with 0x33 unread, send 0x44.
  - Response: rx_data=8'h44, rda=1.
- Reset mid-frame:
  - Stimulus: assert rst=0 for 1 clk during data bit 4 of a frame.
  - Response: all outputs are 0 the next cycle.
  - Then: after rxd idles high for 1 bit, a 0xC3 frame is received correctly.
